// File: rtl/sm4_kat_bist.sv
// Known-answer self-test controller for a pair of SM4 cores: loads the key, runs an
// iterated encrypt chain, checks it against EXP_CT, then decrypts back to PT.
module sm4_kat_bist #(
  parameter int unsigned  ITERATIONS = 1,
  parameter logic [127:0] KEY        = 128'h0123456789ABCDEFFEDCBA9876543210,
  parameter logic [127:0] PT         = 128'h0123456789ABCDEFFEDCBA9876543210,
  parameter logic [127:0] EXP_CT     = 128'h681EDF34D206965E86B3E94F536E4246,
  parameter int unsigned  KEY_WAIT   = 64,
  parameter int unsigned  TIMEOUT    = 1024
) (
  input  logic         CLK_i,
  input  logic         RST_i,
  input  logic         START_i,
  output logic [127:0] MK_o,
  output logic         MK_VALID_o,
  output logic [127:0] ENC_DAT_o,
  output logic         ENC_DAT_VALID_o,
  input  logic [127:0] ENC_DAT_i,
  input  logic         ENC_DAT_READY_i,
  output logic [127:0] DEC_DAT_o,
  output logic         DEC_DAT_VALID_o,
  input  logic [127:0] DEC_DAT_i,
  input  logic         DEC_DAT_READY_i,
  output logic         BUSY_o,
  output logic         DONE_o,
  output logic         PASS_o,
  output logic [1:0]   FAIL_CODE_o,
  output logic [31:0]  ITER_CNT_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_KEYLOAD, S_ENC_ISSUE, S_ENC_WAIT, S_ENC_CHECK,
    S_DEC_ISSUE, S_DEC_WAIT, S_DEC_CHECK, S_FIN
  } state_t;

  localparam logic [31:0] ITER_LIM = ITERATIONS;
  localparam logic [31:0] KW_LIM   = (KEY_WAIT == 0) ? 32'd0 : KEY_WAIT - 1;
  localparam logic [31:0] TMO_LIM  = (TIMEOUT == 0) ? 32'd0 : TIMEOUT - 1;

  state_t         state_reg;
  logic [127:0]   w_reg;
  logic [31:0]    wait_cnt_reg;
  logic [31:0]    tmo_cnt_reg;
  logic [31:0]    iter_cnt_reg;
  logic [127:0]   enc_dat_reg;
  logic [127:0]   dec_dat_reg;
  logic           enc_valid_reg;
  logic           dec_valid_reg;
  logic           mk_valid_reg;
  logic           busy_reg;
  logic           done_reg;
  logic           pass_reg;
  logic [1:0]     fail_code_reg;

  // Both wait states share one capture path; only the selected core's pulse counts.
  logic           in_dec_wait;
  logic           rdy_sel;
  logic [127:0]   dat_sel;
  logic [31:0]    iter_inc;

  assign in_dec_wait = (state_reg == S_DEC_WAIT);
  assign rdy_sel     = in_dec_wait ? DEC_DAT_READY_i : ENC_DAT_READY_i;
  assign dat_sel     = in_dec_wait ? DEC_DAT_i : ENC_DAT_i;
  assign iter_inc    = iter_cnt_reg + 32'd1;

  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      state_reg     <= S_IDLE;
      w_reg         <= '0;
      wait_cnt_reg  <= '0;
      tmo_cnt_reg   <= '0;
      iter_cnt_reg  <= '0;
      enc_dat_reg   <= '0;
      dec_dat_reg   <= '0;
      enc_valid_reg <= 1'b0;
      dec_valid_reg <= 1'b0;
      mk_valid_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      pass_reg      <= 1'b0;
      fail_code_reg <= 2'b00;
    end else begin
      enc_valid_reg <= 1'b0;
      dec_valid_reg <= 1'b0;
      case (state_reg)
        S_IDLE, S_FIN: begin
          if (START_i) begin
            state_reg     <= S_KEYLOAD;
            busy_reg      <= 1'b1;
            mk_valid_reg  <= 1'b1;
            done_reg      <= 1'b0;
            pass_reg      <= 1'b0;
            fail_code_reg <= 2'b00;
            iter_cnt_reg  <= '0;
            wait_cnt_reg  <= '0;
            w_reg         <= PT;
          end
        end
        S_KEYLOAD: begin
          if (wait_cnt_reg >= KW_LIM) begin
            state_reg <= S_ENC_ISSUE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 32'd1;
          end
        end
        S_ENC_ISSUE: begin
          enc_dat_reg   <= w_reg;
          enc_valid_reg <= 1'b1;
          tmo_cnt_reg   <= '0;
          state_reg     <= S_ENC_WAIT;
        end
        S_DEC_ISSUE: begin
          dec_dat_reg   <= w_reg;
          dec_valid_reg <= 1'b1;
          tmo_cnt_reg   <= '0;
          state_reg     <= S_DEC_WAIT;
        end
        S_ENC_WAIT, S_DEC_WAIT: begin
          if (rdy_sel) begin
            w_reg        <= dat_sel;
            iter_cnt_reg <= iter_inc;
            if (iter_inc == ITER_LIM) begin
              state_reg <= in_dec_wait ? S_DEC_CHECK : S_ENC_CHECK;
            end else begin
              state_reg <= in_dec_wait ? S_DEC_ISSUE : S_ENC_ISSUE;
            end
          end else if (tmo_cnt_reg >= TMO_LIM) begin
            state_reg     <= S_FIN;
            busy_reg      <= 1'b0;
            mk_valid_reg  <= 1'b0;
            done_reg      <= 1'b1;
            fail_code_reg <= 2'b11;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 32'd1;
          end
        end
        S_ENC_CHECK: begin
          if (w_reg != EXP_CT) begin
            state_reg     <= S_FIN;
            busy_reg      <= 1'b0;
            mk_valid_reg  <= 1'b0;
            done_reg      <= 1'b1;
            fail_code_reg <= 2'b01;
          end else begin
            iter_cnt_reg <= '0;
            state_reg    <= S_DEC_ISSUE;
          end
        end
        S_DEC_CHECK: begin
          state_reg     <= S_FIN;
          busy_reg      <= 1'b0;
          mk_valid_reg  <= 1'b0;
          done_reg      <= 1'b1;
          pass_reg      <= (w_reg == PT);
          fail_code_reg <= (w_reg == PT) ? 2'b00 : 2'b10;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign MK_o            = KEY;
  assign MK_VALID_o      = mk_valid_reg;
  assign ENC_DAT_o       = enc_dat_reg;
  assign ENC_DAT_VALID_o = enc_valid_reg;
  assign DEC_DAT_o       = dec_dat_reg;
  assign DEC_DAT_VALID_o = dec_valid_reg;
  assign BUSY_o          = busy_reg;
  assign DONE_o          = done_reg;
  assign PASS_o          = pass_reg;
  assign FAIL_CODE_o     = fail_code_reg;
  assign ITER_CNT_o      = iter_cnt_reg;

endmodule

// File: tb/tb_sm4_kat_bist.sv
// Bench for sm4_kat_bist: stand-in cores (byte-rotate cipher) with random latency,
// an event-timed reference model checked every cycle, and literal pins per scenario.
module tb_sm4_kat_bist;

  localparam int unsigned  N_ITER = 5;
  localparam int unsigned  KW     = 64;
  localparam int unsigned  TMO    = 16;
  localparam logic [127:0] KEY_C  = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] PT_C   = 128'h0123456789ABCDEFFEDCBA9876543210;
  // Five left byte-rotations of PT: the top ten hex digits wrap to the bottom.
  localparam logic [127:0] EXP_C  = 128'hABCDEFFEDCBA98765432100123456789;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] mk, enc_do, dec_do;
  logic         mk_valid, enc_v, dec_v, busy, done, pass;
  logic [1:0]   fail_code;
  logic [31:0]  iter_cnt;
  logic [127:0] enc_dat = '0, dec_dat = '0;
  logic         enc_rdy = 1'b0, dec_rdy = 1'b0, spur_rdy = 1'b0;
  logic         enc_ready;
  logic         flip_mode = 1'b0, dec_dead = 1'b0;

  assign enc_ready = enc_rdy | spur_rdy;

  always #5 clk = ~clk;

  sm4_kat_bist #(
    .ITERATIONS(N_ITER), .KEY(KEY_C), .PT(PT_C), .EXP_CT(EXP_C),
    .KEY_WAIT(KW), .TIMEOUT(TMO)
  ) dut (
    .CLK_i(clk), .RST_i(rst), .START_i(start),
    .MK_o(mk), .MK_VALID_o(mk_valid),
    .ENC_DAT_o(enc_do), .ENC_DAT_VALID_o(enc_v), .ENC_DAT_i(enc_dat), .ENC_DAT_READY_i(enc_ready),
    .DEC_DAT_o(dec_do), .DEC_DAT_VALID_o(dec_v), .DEC_DAT_i(dec_dat), .DEC_DAT_READY_i(dec_rdy),
    .BUSY_o(busy), .DONE_o(done), .PASS_o(pass), .FAIL_CODE_o(fail_code), .ITER_CNT_o(iter_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rotl8(input logic [127:0] x);
    return {x[119:0], x[127:120]};
  endfunction

  function automatic logic [127:0] rotr8(input logic [127:0] x);
    return {x[7:0], x[127:8]};
  endfunction

  // Stand-in encryptor: answers every issue pulse after 2..12 cycles.
  initial begin : enc_core
    logic [127:0] x;
    int lat;
    forever begin
      @(posedge clk); #1;
      if (enc_v) begin
        x = enc_do;
        lat = $urandom_range(2, 12);
        repeat (lat - 1) begin @(posedge clk); #1; end
        enc_dat = flip_mode ? (rotl8(x) ^ 128'd1) : rotl8(x);
        enc_rdy = 1'b1;
        @(posedge clk); #1;
        enc_rdy = 1'b0;
      end
    end
  end

  initial begin : dec_core
    logic [127:0] x;
    int lat;
    forever begin
      @(posedge clk); #1;
      if (dec_v && !dec_dead) begin
        x = dec_do;
        lat = $urandom_range(2, 12);
        repeat (lat - 1) begin @(posedge clk); #1; end
        dec_dat = rotr8(x);
        dec_rdy = 1'b1;
        @(posedge clk); #1;
        dec_rdy = 1'b0;
      end
    end
  end

  // Reference model: tracks the test as phases with an issue countdown and a
  // per-block age, predicting the outputs after each upcoming clock edge.
  typedef enum {M_IDLE, M_PEND, M_WAIT, M_CHECK, M_FIN} mph_t;
  mph_t         m_ph = M_IDLE;
  int           m_togo = 0, m_age = 0;
  logic         m_dec = 1'b0;
  logic [127:0] m_w = '0, m_enc_d = '0, m_dec_d = '0;
  logic         m_enc_v = 1'b0, m_dec_v = 1'b0, m_mkv = 1'b0, m_busy = 1'b0;
  logic         m_done = 1'b0, m_pass = 1'b0;
  logic [1:0]   m_code = 2'b00;
  logic [31:0]  m_iter = '0;

  task automatic m_fin(input logic [1:0] code, input logic ok);
    m_ph = M_FIN; m_busy = 1'b0; m_mkv = 1'b0; m_done = 1'b1;
    m_code = code; m_pass = ok;
  endtask

  task automatic model_step();
    m_enc_v = 1'b0;
    m_dec_v = 1'b0;
    if (rst) begin
      m_ph = M_IDLE; m_busy = 1'b0; m_mkv = 1'b0; m_done = 1'b0; m_pass = 1'b0;
      m_code = 2'b00; m_iter = '0; m_enc_d = '0; m_dec_d = '0; m_w = '0; m_dec = 1'b0;
    end else begin
      case (m_ph)
        M_IDLE, M_FIN: if (start) begin
          m_ph = M_PEND; m_togo = KW + 1; m_busy = 1'b1; m_mkv = 1'b1;
          m_done = 1'b0; m_pass = 1'b0; m_code = 2'b00; m_iter = '0;
          m_w = PT_C; m_dec = 1'b0;
        end
        M_PEND: begin
          m_togo--;
          if (m_togo == 0) begin
            if (m_dec) begin m_dec_v = 1'b1; m_dec_d = m_w; end
            else begin m_enc_v = 1'b1; m_enc_d = m_w; end
            m_age = 0;
            m_ph = M_WAIT;
          end
        end
        M_WAIT: begin
          if (m_dec ? dec_rdy : enc_ready) begin
            m_w = m_dec ? dec_dat : enc_dat;
            m_iter++;
            if (m_iter == N_ITER) m_ph = M_CHECK;
            else begin m_ph = M_PEND; m_togo = 1; end
          end else begin
            m_age++;
            if (m_age == TMO) m_fin(2'b11, 1'b0);
          end
        end
        M_CHECK: begin
          if (!m_dec) begin
            if (m_w != EXP_C) m_fin(2'b01, 1'b0);
            else begin m_dec = 1'b1; m_iter = '0; m_ph = M_PEND; m_togo = 1; end
          end else if (m_w == PT_C) m_fin(2'b00, 1'b1);
          else m_fin(2'b10, 1'b0);
        end
        default: m_ph = M_IDLE;
      endcase
    end
  endtask

  int           cyc = 0;
  int           enc_pulses = 0, dec_pulses = 0;
  int           dec_v_cyc = 0, done_cyc = 0;
  logic         done_seen = 1'b0, prev_done = 1'b0;
  logic [127:0] first_enc = '0, first_dec = '0;

  always @(negedge clk) begin
    cyc++;
    chk("mk", mk, KEY_C);
    chk("mk_valid", 128'(mk_valid), 128'(m_mkv));
    chk("busy", 128'(busy), 128'(m_busy));
    chk("done", 128'(done), 128'(m_done));
    chk("pass", 128'(pass), 128'(m_pass));
    chk("fail_code", 128'(fail_code), 128'(m_code));
    chk("iter_cnt", 128'(iter_cnt), 128'(m_iter));
    chk("enc_valid", 128'(enc_v), 128'(m_enc_v));
    chk("dec_valid", 128'(dec_v), 128'(m_dec_v));
    chk("enc_dat", enc_do, m_enc_d);
    chk("dec_dat", dec_do, m_dec_d);
    if (enc_v) begin
      if (enc_pulses == 0) first_enc = enc_do;
      enc_pulses++;
    end
    if (dec_v) begin
      if (dec_pulses == 0) begin first_dec = dec_do; dec_v_cyc = cyc; end
      dec_pulses++;
    end
    if (done && !prev_done) begin done_seen = 1'b1; done_cyc = cyc; end
    prev_done = done;
    model_step();
  end

  task automatic begin_test(input logic flip, input logic dead);
    repeat ($urandom_range(1, 5)) @(posedge clk);
    #1;
    flip_mode = flip; dec_dead = dead;
    enc_pulses = 0; dec_pulses = 0; done_seen = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done_seen && n < 3000) begin @(negedge clk); n++; end
    @(negedge clk);
    checks++;
    if (!done_seen) begin
      errors++;
      $display("FAIL %s_done actual=DONE_o stayed 0 for %0d cycles required=DONE_o 1", name, n);
    end
    $display("run %s: done=%0d pass=%0d code=%0d iter=%0d enc_pulses=%0d dec_pulses=%0d",
             name, done, pass, fail_code, iter_cnt, enc_pulses, dec_pulses);
  endtask

  task automatic wait_enc_pulses(input int k);
    int n = 0;
    while (enc_pulses < k && n < 3000) begin @(negedge clk); n++; end
    checks++;
    if (enc_pulses < k) begin
      errors++;
      $display("FAIL enc_pulse_wait actual=%0d required=%0d", enc_pulses, k);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mk_lit", mk, 128'h0123456789ABCDEFFEDCBA9876543210);
    chk("rst_busy_lit", 128'(busy), 128'd0);
    chk("rst_done_lit", 128'(done), 128'd0);
    chk("rst_enc_dat_lit", enc_do, 128'd0);

    for (int r = 0; r < 3; r++) begin
      begin_test(1'b0, 1'b0);
      wait_done("pass");
      chk("pass_lit", 128'(pass), 128'd1);
      chk("pass_code_lit", 128'(fail_code), 128'd0);
      chk("pass_iter_lit", 128'(iter_cnt), 128'd5);
      chk("pass_first_enc_lit", first_enc, 128'h0123456789ABCDEFFEDCBA9876543210);
      chk("pass_first_dec_lit", first_dec, 128'hABCDEFFEDCBA98765432100123456789);
      chk("pass_enc_pulses", 128'(enc_pulses), 128'd5);
    end

    begin_test(1'b1, 1'b0);
    wait_done("ct_flip");
    chk("flip_code_lit", 128'(fail_code), 128'd1);
    chk("flip_no_dec_lit", 128'(dec_pulses), 128'd0);
    chk("flip_pass_lit", 128'(pass), 128'd0);

    begin_test(1'b0, 1'b1);
    wait_done("dec_timeout");
    chk("tmo_code_lit", 128'(fail_code), 128'd3);
    chk("tmo_busy_lit", 128'(busy), 128'd0);
    chk("tmo_delay_lit", 128'(done_cyc - dec_v_cyc), 128'd16);
    chk("tmo_iter_lit", 128'(iter_cnt), 128'd0);

    begin_test(1'b0, 1'b0);
    wait_enc_pulses(3);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy_lit", 128'(busy), 128'd0);
    chk("abort_mkv_lit", 128'(mk_valid), 128'd0);
    chk("abort_iter_lit", 128'(iter_cnt), 128'd0);
    chk("abort_enc_dat_lit", enc_do, 128'd0);
    $display("run abort: busy=%0d done=%0d iter=%0d", busy, done, iter_cnt);
    begin_test(1'b0, 1'b0);
    wait_done("after_abort");
    chk("after_abort_pass_lit", 128'(pass), 128'd1);

    begin_test(1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1 spur_rdy = 1'b1;
    @(posedge clk); #1 spur_rdy = 1'b0;
    wait_enc_pulses(1);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("ignored_inputs");
    chk("ignored_pass_lit", 128'(pass), 128'd1);
    chk("ignored_iter_lit", 128'(iter_cnt), 128'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
